// File: rtl/mul3_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mul3_seq_ctrl_if
// Description : Operand/product handshake bundle for mul3_seq_ctrl.
//               slave  = controller side, master = producer/consumer side.
// Revision    : 1.0  initial release
// ============================================================================
interface mul3_seq_ctrl_if #(
    parameter int W = 6
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           busy;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );
endinterface
`default_nettype wire

// File: rtl/mul3_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul3_seq_ctrl (+ Mult_3_3 core)
// Description : WxW unsigned multiplier built by time-sharing a single 3x3
//               core. One digit pair per cycle, shift-accumulated into a
//               2W-bit register; valid/ready on both sides.
// Revision    : 1.0  initial release
// ============================================================================
module mul3_seq_ctrl #(
    parameter int W = 6
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mul3_seq_ctrl_if.slave    bus
);
    localparam int D     = W / 3;
    localparam int IW    = (D > 1) ? $clog2(D) : 1;
    localparam int PW    = 2 * W;
    localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

    // Reject unsupported operand widths at elaboration time.
    if ((W % 3) != 0 || W < 3 || W > 12) begin : g_bad_width
        $error("mul3_seq_ctrl: W must be a multiple of 3 in 3..12");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;
    logic [2:0]      da_q, da_d;
    logic [2:0]      db_q, db_d;

    logic [5:0]      w_prod;
    logic            w_last;
    logic [IW-1:0]   w_ni;
    logic [IW-1:0]   w_nj;
    logic [31:0]     w_sh;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_busy;

    // Select 3-bit digit k of an operand.
    function automatic logic [2:0] digit(input logic [W-1:0] v, input logic [IW-1:0] k);
        logic [W-1:0] t;
        t = v >> (32'd3 * 32'(k));
        return t[2:0];
    endfunction

    // The single shared core; its inputs come straight from digit registers.
    Mult_3_3 u_core (
        .a_i (da_q),
        .b_i (db_q),
        .p_o (w_prod)
    );

    assign w_last = (i_q == LAST_IDX) && (j_q == LAST_IDX);
    assign w_sh   = 32'd3 * (32'(i_q) + 32'(j_q));

    // Step order: j fastest, then i.
    assign w_ni = (j_q == LAST_IDX) ? i_q + 1'b1 : i_q;
    assign w_nj = (j_q == LAST_IDX) ? '0 : j_q + 1'b1;

    // State register; reset overrides any handshake.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake decode (outputs forced low during reset).
    always_comb begin
        state_d     = state_q;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_in_ready = !rst;
                if (bus.in_valid) state_d = S_RUN;
            end
            S_RUN: begin
                w_busy = !rst;
                if (w_last) state_d = S_DONE;
            end
            S_DONE: begin
                w_busy      = !rst;
                w_out_valid = !rst;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture on accept, accumulate one digit pair per RUN cycle.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        i_d   = i_q;
        j_d   = j_q;
        da_d  = da_q;
        db_d  = db_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d   = bus.in_a;
                    b_d   = bus.in_b;
                    acc_d = '0;
                    i_d   = '0;
                    j_d   = '0;
                    da_d  = bus.in_a[2:0];
                    db_d  = bus.in_b[2:0];
                end
            end
            S_RUN: begin
                acc_d = acc_q + (PW'(w_prod) << w_sh);
                if (w_last) begin
                    // Park the core on zero until the next operation.
                    i_d  = '0;
                    j_d  = '0;
                    da_d = '0;
                    db_d = '0;
                end else begin
                    i_d  = w_ni;
                    j_d  = w_nj;
                    da_d = digit(a_q, w_ni);
                    db_d = digit(b_q, w_nj);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            da_q  <= '0;
            db_q  <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            i_q   <= i_d;
            j_q   <= j_d;
            da_q  <= da_d;
            db_q  <= db_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_p     = acc_q;
endmodule

// ----------------------------------------------------------------------------
// Mult_3_3 : 3x3 unsigned multiplier. AND-array partial products, one
// Wallace reduction layer down to two rows, ripple-carry final adder.
// ----------------------------------------------------------------------------
module Mult_3_3 (
    input  wire logic [2:0] a_i,
    input  wire logic [2:0] b_i,
    output logic      [5:0] p_o
);
    logic [2:0] w_pp0, w_pp1, w_pp2;
    logic       w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;
    logic [4:0] w_x, w_y;
    logic [5:0] w_cy;

    assign w_pp0 = a_i & {3{b_i[0]}};
    assign w_pp1 = a_i & {3{b_i[1]}};
    assign w_pp2 = a_i & {3{b_i[2]}};

    // Reduction layer: HA on weight 1, FA on weight 2, HA on weight 3.
    assign w_s1 = w_pp0[1] ^ w_pp1[0];
    assign w_c1 = w_pp0[1] & w_pp1[0];
    assign w_s2 = w_pp0[2] ^ w_pp1[1] ^ w_pp2[0];
    assign w_c2 = (w_pp0[2] & w_pp1[1]) | (w_pp0[2] & w_pp2[0]) | (w_pp1[1] & w_pp2[0]);
    assign w_s3 = w_pp1[2] ^ w_pp2[1];
    assign w_c3 = w_pp1[2] & w_pp2[1];

    assign w_x = {w_pp2[2], w_s3, w_s2, w_s1, w_pp0[0]};
    assign w_y = {w_c3, w_c2, w_c1, 2'b00};

    assign w_cy[0] = 1'b0;
    for (genvar k = 0; k < 5; k++) begin : g_rca
        assign p_o[k]    = w_x[k] ^ w_y[k] ^ w_cy[k];
        assign w_cy[k+1] = (w_x[k] & w_y[k]) | (w_x[k] & w_cy[k]) | (w_y[k] & w_cy[k]);
    end
    assign p_o[5] = w_cy[5];
endmodule
`default_nettype wire

// File: tb/tb_mul3_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul3_seq_ctrl
// Description : Self-checking bench for mul3_seq_ctrl (W=6 main instance,
//               plus W=3 and W=12 instances for parameter coverage).
// Revision    : 1.0  initial release
// ============================================================================
module tb_mul3_seq_ctrl;
    localparam int NN = 4;   // D*D for W=6

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul3_seq_ctrl_if #(.W(6))  bus   ();
    mul3_seq_ctrl_if #(.W(3))  bus3  ();
    mul3_seq_ctrl_if #(.W(12)) bus12 ();

    mul3_seq_ctrl #(.W(6))  dut   (.clk(clk), .rst(rst), .bus(bus));
    mul3_seq_ctrl #(.W(3))  dut3  (.clk(clk), .rst(rst), .bus(bus3));
    mul3_seq_ctrl #(.W(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model (W=6) ---------------
    int      cyc     = 0;
    bit      m_busy  = 1'b0;
    bit      m_valid = 1'b0;
    bit      m_p0    = 1'b0;  // out_p known to be zero (post-reset, pre-accept)
    int      m_cnt   = 0;
    longint  m_prod  = 0;
    int      acc_cyc[$];
    int      xfer_cyc[$];
    longint  got_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_p0    = 1'b1;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_prod = longint'(bus.in_a) * longint'(bus.in_b);
                m_p0   = 1'b0;
                acc_cyc.push_back(cyc);
            end
        end else if (!m_valid) begin
            m_cnt++;
            if (m_cnt == NN) m_valid = 1'b1;
        end else if (bus.out_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            xfer_cyc.push_back(cyc);
        end
        cyc++;
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        #1;
        check("in_ready",  longint'(bus.in_ready),  longint'(!rst && !m_busy));
        check("busy",      longint'(bus.busy),      longint'(m_busy && !rst));
        check("out_valid", longint'(bus.out_valid), longint'(m_valid && !rst));
        if (m_valid && !rst) begin
            check("out_p", longint'(bus.out_p), m_prod);
            if (bus.out_ready) got_q.push_back(longint'(bus.out_p));
        end else if (m_p0) begin
            check("out_p_after_reset", longint'(bus.out_p), 0);
        end
    end

    // ---------------- directed operation helper --------------------------
    task automatic run_op(input logic [5:0] a, input logic [5:0] b, input int stall,
                          output longint p, output int lat, output int busy_cyc);
        int g;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = (stall == 0);
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("accept_timeout", 0, 1);
        @(posedge clk);                       // accept edge, cycle 0
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = 6'($urandom);
        bus.in_b     = 6'($urandom);
        lat      = 1;
        busy_cyc = 0;
        while (1) begin
            #1;
            if (bus.busy) busy_cyc++;
            if (bus.out_valid || lat >= 40) break;
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) check("valid_timeout", 0, 1);
        p = longint'(bus.out_p);
        if (stall > 0) begin
            for (int s = 1; s < stall; s++) begin
                @(negedge clk);
                #1;
                check("stall_in_ready", longint'(bus.in_ready), 0);
                check("stall_out_p", longint'(bus.out_p), longint'(a) * longint'(b));
            end
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    int order[4096];

    initial begin
        longint p, sum;
        int lat, bc, g, n0, x0, g0, s0, idx, seen, target, lat3, lat12, cnt;
        longint p3, p12;
        logic [5:0] ta[4];
        logic [5:0] tb[4];
        longint     te[4];

        bus.in_valid = 0;   bus.in_a = 0;   bus.in_b = 0;   bus.out_ready = 0;
        bus3.in_valid = 0;  bus3.in_a = 0;  bus3.in_b = 0;  bus3.out_ready = 0;
        bus12.in_valid = 0; bus12.in_a = 0; bus12.in_b = 0; bus12.out_ready = 0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_in_ready",  longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_busy",      longint'(bus.busy), 0);
        check("rst_out_p",     longint'(bus.out_p), 0);

        // ---- W=3 and W=12 coverage ----
        @(negedge clk);
        bus3.in_valid = 1;  bus3.in_a = 3'd7;      bus3.in_b = 3'd7;      bus3.out_ready = 1;
        bus12.in_valid = 1; bus12.in_a = 12'd4095; bus12.in_b = 12'd4095; bus12.out_ready = 1;
        check("w3_in_ready",  longint'(bus3.in_ready), 1);
        check("w12_in_ready", longint'(bus12.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus3.in_valid = 0;
        bus12.in_valid = 0;
        lat3 = -1; lat12 = -1; p3 = 0; p12 = 0;
        for (int c = 1; c <= 24; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (bus3.out_valid && lat3 < 0)   begin lat3 = c;  p3  = longint'(bus3.out_p);  end
            if (bus12.out_valid && lat12 < 0) begin lat12 = c; p12 = longint'(bus12.out_p); end
        end
        check("w3_latency",  lat3, 2);
        check("w3_product",  p3, 49);
        check("w12_latency", lat12, 17);
        check("w12_product", p12, 16769025);

        // ---- 63 x 63 ----
        run_op(6'd63, 6'd63, 0, p, lat, bc);
        check("max_latency", lat, 5);
        check("max_product", p, 3969);
        check("max_busy_cycles", bc, 5);

        // ---- small table ----
        ta = '{6'd0, 6'd5, 6'd1, 6'd42};
        tb = '{6'd45, 6'd7, 6'd1, 6'd21};
        te = '{0, 35, 1, 882};
        for (int k = 0; k < 4; k++) begin
            run_op(ta[k], tb[k], 0, p, lat, bc);
            check("table_product", p, te[k]);
        end

        // ---- backpressure 13 x 9 ----
        x0 = xfer_cyc.size();
        g0 = got_q.size();
        run_op(6'd13, 6'd9, 4, p, lat, bc);
        check("bp_product", p, 117);
        check("bp_transfers", xfer_cyc.size() - x0, 1);
        if (got_q.size() == g0 + 1) check("bp_got", got_q[g0], 117);
        else                        check("bp_got_count", got_q.size() - g0, 1);

        // ---- back-to-back 10x11 then 3x60 ----
        n0 = acc_cyc.size(); x0 = xfer_cyc.size(); g0 = got_q.size();
        @(negedge clk);
        bus.in_valid = 1; bus.in_a = 6'd10; bus.in_b = 6'd11; bus.out_ready = 1;
        g = 0;
        while (acc_cyc.size() < n0 + 1 && g < 50) begin @(negedge clk); g++; end
        bus.in_a = 6'd3; bus.in_b = 6'd60;
        g = 0;
        while (acc_cyc.size() < n0 + 2 && g < 50) begin @(negedge clk); g++; end
        bus.in_valid = 0;
        g = 0;
        while (xfer_cyc.size() < x0 + 2 && g < 50) begin @(negedge clk); g++; end
        if (acc_cyc.size() >= n0 + 2 && xfer_cyc.size() >= x0 + 2 && got_q.size() >= g0 + 2) begin
            check("b2b_first",  got_q[g0], 110);
            check("b2b_second", got_q[g0+1], 180);
            check("b2b_accept_after_xfer", acc_cyc[n0+1] - xfer_cyc[x0], 1);
            check("b2b_period", acc_cyc[n0+1] - acc_cyc[n0], 6);
        end else begin
            check("b2b_timeout", 0, 1);
        end

        // ---- reset mid-RUN ----
        g0 = got_q.size();
        @(negedge clk);
        bus.in_valid = 1; bus.in_a = 6'd50; bus.in_b = 6'd50; bus.out_ready = 1;
        g = 0;
        while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);          // accept, cycle 0
        @(negedge clk);          // cycle 1
        bus.in_valid = 0;
        @(negedge clk);          // cycle 2
        rst = 1'b1;
        @(negedge clk);          // cycle 3
        #2;
        check("abort_out_valid", longint'(bus.out_valid), 0);
        check("abort_busy",      longint'(bus.busy), 0);
        check("abort_out_p",     longint'(bus.out_p), 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("abort_in_ready", longint'(bus.in_ready), 1);
        run_op(6'd2, 6'd3, 0, p, lat, bc);
        check("post_reset_product", p, 6);
        cnt = 0;
        for (int k = g0; k < got_q.size(); k++) if (got_q[k] == 2500) cnt++;
        check("no_stale_result", cnt, 0);
        check("post_reset_transfers", got_q.size() - g0, 1);

        // ---- randomized sweep of all 4096 pairs ----
        for (int k = 0; k < 4096; k++) order[k] = k;
        for (int k = 4095; k > 0; k--) begin
            int r, t;
            r = int'($urandom_range(k, 0));
            t = order[k]; order[k] = order[r]; order[r] = t;
        end
        s0     = got_q.size();
        x0     = xfer_cyc.size();
        seen   = acc_cyc.size();
        target = x0 + 4096;
        idx    = 0;
        g      = 0;
        while (xfer_cyc.size() < target && g < 60000) begin
            @(negedge clk);
            g++;
            if (acc_cyc.size() > seen) begin
                seen = acc_cyc.size();
                idx++;
            end
            if (idx < 4096 && $urandom_range(3, 0) != 0) begin
                bus.in_valid = 1;
                bus.in_a = 6'(order[idx] >> 6);
                bus.in_b = 6'(order[idx] & 63);
            end else begin
                bus.in_valid = 0;
                bus.in_a = 6'($urandom);
                bus.in_b = 6'($urandom);
            end
            bus.out_ready = ($urandom_range(3, 0) != 0);
        end
        bus.in_valid = 0;
        check("sweep_transfers", xfer_cyc.size() - x0, 4096);
        sum = 0;
        for (int k = s0; k < got_q.size(); k++) sum += got_q[k];
        check("sweep_sum", sum, 64'd4064256);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
